// File: rtl/note_peak_sched.sv
// note_peak_sched: per-frame peak-bin picker and note scheduler.
// Scans each FFT magnitude frame for the strongest bin in [BIN_LO, BIN_HI].
// It presents that bin to an external note lookup and registers the note
// the lookup returns. Frames whose peak is at or below i_thresh count as
// silent. Above-threshold notes are handed downstream on a valid/ready
// handshake. Frames that start while the block is busy are dropped and
// counted.
// Optional feature macro: NOTE_DEBOUNCE_EN. When it is defined, a note is
// emitted only after it has been the peak for STABLE_FRAMES consecutive
// above-threshold frames.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_thresh            minimum peak magnitude for a valid note
//   i_mag, i_mag_valid  magnitude beat and its qualifier
//   i_mag_sop/eop       first/last beat of a frame
//   o_bin_idx           peak bin (zero-extended) to the note lookup
//   i_note              lookup result, combinational on o_bin_idx
//   o_note, o_note_valid, i_note_ready   downstream note handshake
//   o_busy              high while in LOOKUP/DECIDE/OUTPUT
//   o_drop_cnt          saturating count of frames dropped while busy
module note_peak_sched #(
    parameter int unsigned MAG_W         = 24,
    parameter int unsigned BIN_W         = 10,
    parameter int unsigned BIN_LO        = 13,
    parameter int unsigned BIN_HI        = 57,
    parameter int unsigned STABLE_FRAMES = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [MAG_W-1:0] i_thresh,
    input  logic [MAG_W-1:0] i_mag,
    input  logic             i_mag_valid,
    input  logic             i_mag_sop,
    input  logic             i_mag_eop,
    output logic [31:0]      o_bin_idx,
    input  logic [4:0]       i_note,
    output logic [4:0]       o_note,
    output logic             o_note_valid,
    input  logic             i_note_ready,
    output logic             o_busy,
    output logic [7:0]       o_drop_cnt
);

    localparam int unsigned DROP_W = 8;
    localparam int unsigned NOTE_W = 5;
    localparam logic [BIN_W-1:0] CNT_MAX = '1;

    // Reject parameter sets that cannot work.
    if (BIN_LO < 1 || BIN_HI < BIN_LO || STABLE_FRAMES < 1 || BIN_HI >= (1 << BIN_W)) begin : g_param_err
        $error("note_peak_sched: bad parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_LOOKUP,
        S_DECIDE,
        S_OUTPUT
    } state_t;

    state_t              state, state_nxt;
    logic [BIN_W-1:0]    cnt, cnt_nxt;
    logic [MAG_W-1:0]    max_q, max_nxt;
    logic [BIN_W-1:0]    peak_q, peak_nxt;
    logic [NOTE_W-1:0]   note_q, note_nxt;
    logic [NOTE_W-1:0]   out_note_nxt;
    logic                valid_nxt;
    logic                busy_nxt;
    logic [DROP_W-1:0]   drop_nxt;

`ifdef NOTE_DEBOUNCE_EN
    localparam int unsigned STAB_W = $clog2(STABLE_FRAMES + 1);
    localparam logic [STAB_W-1:0] STAB_TGT = STAB_W'(STABLE_FRAMES);
    // stab == 0 means there is no candidate yet.
    logic [NOTE_W-1:0]   cand, cand_nxt;
    logic [STAB_W-1:0]   stab, stab_nxt;
`endif

    // Scan datapath for one beat. A sop beat is bin 0 of a fresh frame.
    logic [BIN_W-1:0]    base_cnt, base_peak, scan_cnt, scan_peak;
    logic [MAG_W-1:0]    base_max, scan_max;
    logic                in_win;
    logic                sop_beat;

    always_comb begin : scan_path
        base_cnt  = i_mag_sop ? '0 : cnt;
        base_max  = i_mag_sop ? '0 : max_q;
        base_peak = i_mag_sop ? '0 : peak_q;
        in_win    = (base_cnt >= BIN_W'(BIN_LO)) && (base_cnt <= BIN_W'(BIN_HI));
        scan_cnt  = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + BIN_W'(1);
        // A strict compare keeps the lower bin on ties.
        if (in_win && (i_mag > base_max)) begin
            scan_max  = i_mag;
            scan_peak = base_cnt;
        end else begin
            scan_max  = base_max;
            scan_peak = base_peak;
        end
    end

    assign sop_beat = i_mag_valid && i_mag_sop;

    // Next-state and next-output logic.
    always_comb begin : fsm_comb
        state_nxt    = state;
        cnt_nxt      = cnt;
        max_nxt      = max_q;
        peak_nxt     = peak_q;
        note_nxt     = note_q;
        out_note_nxt = o_note;
        drop_nxt     = o_drop_cnt;
`ifdef NOTE_DEBOUNCE_EN
        cand_nxt     = cand;
        stab_nxt     = stab;
`endif
        // A frame starting while busy is dropped; its later beats are ignored by IDLE.
        if (sop_beat && (state == S_LOOKUP || state == S_DECIDE || state == S_OUTPUT)
            && (o_drop_cnt != '1)) begin
            drop_nxt = o_drop_cnt + DROP_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (sop_beat) begin
                    cnt_nxt   = scan_cnt;
                    max_nxt   = scan_max;
                    peak_nxt  = scan_peak;
                    state_nxt = i_mag_eop ? S_LOOKUP : S_SCAN;
                end
            end
            S_SCAN: begin
                if (i_mag_valid) begin
                    cnt_nxt  = scan_cnt;
                    max_nxt  = scan_max;
                    peak_nxt = scan_peak;
                    if (i_mag_eop) begin
                        state_nxt = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                note_nxt  = i_note;
                state_nxt = S_DECIDE;
            end
            S_DECIDE: begin
                state_nxt = S_IDLE;
`ifdef NOTE_DEBOUNCE_EN
                if (max_q <= i_thresh) begin
                    cand_nxt = '0;
                    stab_nxt = '0;
                end else begin
                    if (note_q == cand) begin
                        stab_nxt = (stab == STAB_TGT) ? stab : stab + STAB_W'(1);
                    end else begin
                        cand_nxt = note_q;
                        stab_nxt = STAB_W'(1);
                    end
                    // Emit only on the frame that makes the count reach the target.
                    if ((stab_nxt == STAB_TGT) && ((stab != STAB_TGT) || (note_q != cand))) begin
                        out_note_nxt = note_q;
                        state_nxt    = S_OUTPUT;
                    end
                end
`else
                if (max_q > i_thresh) begin
                    out_note_nxt = note_q;
                    state_nxt    = S_OUTPUT;
                end
`endif
            end
            S_OUTPUT: begin
                if (i_note_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        valid_nxt = (state_nxt == S_OUTPUT);
        busy_nxt  = (state_nxt == S_LOOKUP) || (state_nxt == S_DECIDE) || (state_nxt == S_OUTPUT);
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            max_q        <= '0;
            peak_q       <= '0;
            note_q       <= '0;
            o_note       <= '0;
            o_note_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_drop_cnt   <= '0;
`ifdef NOTE_DEBOUNCE_EN
            cand         <= '0;
            stab         <= '0;
`endif
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            max_q        <= max_nxt;
            peak_q       <= peak_nxt;
            note_q       <= note_nxt;
            o_note       <= out_note_nxt;
            o_note_valid <= valid_nxt;
            o_busy       <= busy_nxt;
            o_drop_cnt   <= drop_nxt;
`ifdef NOTE_DEBOUNCE_EN
            cand         <= cand_nxt;
            stab         <= stab_nxt;
`endif
        end
    end

    // peak_q is a register and does not change outside IDLE/SCAN.
    assign o_bin_idx = 32'(peak_q);

endmodule

// File: doc/note_peak_sched.md
# note_peak_sched

Frame-level controller between the FFT magnitude stream and the bin-to-note lookup. Per FFT frame, it scans the magnitude stream for the peak bin inside the piano bin window and presents that bin index to the lookup. It registers the returned note, applies a threshold and an optional stability filter, and hands the note downstream with a valid/ready handshake. It also counts frames it had to drop while busy.

## Interface
- MAG_W, 24, magnitude width (unsigned)
- BIN_W, 10, internal bin counter width
- BIN_LO, 13, lowest bin considered (must be ≥1)
- BIN_HI, 57, highest bin considered
- STABLE_FRAMES, 3, consecutive identical frames needed before emit (≥1)

- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_thresh  in  MAG_W  minimum peak magnitude for a valid note
- i_mag  in  MAG_W  FFT magnitude beat
- i_mag_valid  in  1  beat qualifier
- i_mag_sop  in  1  first beat of frame (bin 0), qualified by valid
- i_mag_eop  in  1  last beat of frame, qualified by valid
- o_bin_idx  out  32  peak bin, zero-extended, to note lookup
- i_note  in  5  note from lookup (combinational on o_bin_idx)
- o_note  out  5  emitted note
- o_note_valid  out  1  note handshake valid
- i_note_ready  in  1  note handshake ready
- o_busy  out  1  high in LOOKUP/DECIDE/OUTPUT
- o_drop_cnt  out  8  frames dropped, saturating

## Operation
- States: IDLE, SCAN, LOOKUP, DECIDE, OUTPUT.
- IDLE: on valid&sop, go to SCAN. Bin counter is set to 0 for that beat, and max/peak_bin are cleared. The beat is processed like any SCAN beat.
- SCAN: each valid beat at bin b:
  - If BIN_LO≤b≤BIN_HI and i_mag > max (strict), update max=i_mag and peak_bin=b. Ties keep the lower bin.
  - The counter then increments, saturating at 2^BIN_W−1.
  - Non-valid cycles hold all state.
- SCAN + valid&sop (not the first beat): restart the frame and clear max/peak_bin. The abandoned frame is not counted as dropped.
- SCAN + valid&eop: go to LOOKUP. sop and eop on the same beat form a one-bin frame.
- LOOKUP: o_bin_idx = peak_bin. One cycle for the lookup to settle. Register i_note at the end of the cycle. Go to DECIDE.
- DECIDE:
  - If max ≤ i_thresh, the frame is silent. Clear the candidate and stab_cnt, and go to IDLE with no emit.
  - Otherwise, if note == candidate, stab_cnt = min(stab_cnt+1, STABLE_FRAMES). If not, candidate = note and stab_cnt = 1.
  - Emit when stab_cnt transitions to STABLE_FRAMES in this cycle. On emit go to OUTPUT, otherwise go to IDLE.
- OUTPUT: o_note_valid=1 and o_note=candidate, held stable until i_note_ready. On valid&ready go to IDLE.
- A valid&sop seen in LOOKUP/DECIDE/OUTPUT drops the frame: o_drop_cnt++ (saturating at 255) and the rest of that frame is ignored. Only sop beats are counted.
- Reset, including mid-frame: all state is cleared and the frame is abandoned. o_note=0, o_note_valid=0, o_bin_idx=0, o_busy=0, o_drop_cnt=0, state IDLE, candidate none, stab_cnt=0.

## Timing
- eop beat in cycle T: LOOKUP at T+1, DECIDE at T+2, o_note_valid high at T+3 at the earliest.
- With i_note_ready high at T+3: o_note_valid falls at T+4 and state is IDLE at T+4. A sop at T+4 is accepted.
- o_busy is high from T+1 until the cycle the state returns to IDLE.
- o_note and o_note_valid are registered outputs. o_bin_idx is registered and stable throughout LOOKUP.
- i_thresh is sampled in DECIDE only.

## Configuration
- NOTE_DEBOUNCE_EN defined: the stability filter operates as described above.
- NOTE_DEBOUNCE_EN undefined: STABLE_FRAMES is ignored. Every above-threshold frame goes DECIDE→OUTPUT with o_note=i_note as registered, and no candidate/stab_cnt logic is generated.

## Test plan
- Debounce off, thresh 100, frame with bin 30 = 1000 and all others 10 → o_bin_idx=30 during LOOKUP, o_note=13 valid at eop+3, cleared at eop+4 with ready high.
- Tie: bins 20 and 44 both 500, rest 0 → peak_bin=20, o_note=6.
- Bin 60 = 50000, in-window max 50, thresh 100 → no o_note_valid, state IDLE at eop+3.
- Debounce on, STABLE_FRAMES=3:
  - Four frames peaking at bin 30 → exactly one emit (note 13), after the third frame.
  - Then one silent frame, then three more bin-30 frames → a second emit.
- Ready held low for 20 cycles while a full frame (sop..eop) arrives → o_note held at 13, o_drop_cnt=1, the dropped frame has no effect on the candidate.
- i_rst pulsed mid-SCAN → all outputs 0 asynchronously, then the next frame (bin 25 peak) emits note 10.
